// File: rtl/fir_decim_out.sv
// fir_decim_out: block-average decimator with registered-head output FIFO; FIR_DECIM_ROUND_EN enables round-half-up
module fir_decim_out #(
  parameter int LOG2_DECIM = 2,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            i_y,
  input  logic                  i_valid,
  output logic [7:0]            o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_ovf,
  output logic [LOG2_DEPTH:0]   o_level
);
  localparam int W = 8 + LOG2_DECIM;
  localparam int P = LOG2_DEPTH + 1;
  localparam int DEPTH = 1 << LOG2_DEPTH;
  logic [W-1:0] acc, sum, rnd;
  logic [LOG2_DECIM-1:0] cnt;
  logic [7:0] mem [DEPTH];
  logic [P-1:0] wr_ptr, rd_ptr, rd_next;
  logic [7:0] result, head_next;
  logic last, full, do_push, do_pop, wr_en;
  assign sum = acc + W'(i_y);
`ifdef FIR_DECIM_ROUND_EN
  assign rnd = sum + W'(1 << (LOG2_DECIM - 1));
`else
  assign rnd = sum;
`endif
  assign result = rnd[W-1:LOG2_DECIM];
  assign last = cnt == '1;
  assign o_level = wr_ptr - rd_ptr;
  assign o_valid = wr_ptr != rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {LOG2_DEPTH{1'b0}}};
  assign do_push = i_valid && last;
  assign do_pop = o_valid && i_ready;
  assign wr_en = do_push && (!full || do_pop);
  assign rd_next = rd_ptr + P'(do_pop);
  // a push into a FIFO that is (or becomes) empty bypasses straight to the head register
  assign head_next = (wr_en && rd_next == wr_ptr) ? result : mem[rd_next[LOG2_DEPTH-1:0]];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[LOG2_DEPTH-1:0]] <= result;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_data <= '0;
      o_ovf <= 1'b0;
    end else begin
      if (i_valid) begin
        acc <= last ? '0 : sum;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      wr_ptr <= wr_ptr + P'(wr_en);
      rd_ptr <= rd_next;
      o_data <= head_next;
      if (do_push && full && !do_pop) o_ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_decim_out.sv
// tb_fir_decim_out: directed test-plan sequences plus random traffic against a queue-based reference model
module tb_fir_decim_out;
  localparam int D = 4;
  localparam int DEPTH = 4;
`ifdef FIR_DECIM_ROUND_EN
  localparam int RB = D / 2;
`else
  localparam int RB = 0;
`endif
  logic clk = 0, rst_n = 0, i_valid = 0, i_ready = 0;
  logic [7:0] i_y = 0, o_data;
  logic o_valid, o_ovf;
  logic [2:0] o_level;
  int errors = 0, checks = 0;
  int grp[$];
  int fq[$];
  bit movf;

  fir_decim_out dut (
    .clk(clk), .rst_n(rst_n), .i_y(i_y), .i_valid(i_valid), .o_data(o_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_ovf(o_ovf), .o_level(o_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("level", 32'(o_level), 32'(fq.size()));
    chk("valid", 32'(o_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) chk("data", 32'(o_data), 32'(fq[0]));
    chk("ovf", 32'(o_ovf), 32'(movf));
  endtask

  task automatic step(input bit v, input logic [7:0] y, input bit r);
    bit pop, push;
    int s, res;
    i_valid = v;
    i_y = y;
    i_ready = r;
    pop = r && fq.size() > 0;
    push = 0;
    res = 0;
    if (v) begin
      grp.push_back(int'(y));
      if (grp.size() == D) begin
        s = 0;
        foreach (grp[k]) s += grp[k];
        res = (s + RB) / D;
        push = 1;
        grp.delete();
      end
    end
    @(posedge clk); #1;
    if (pop) void'(fq.pop_front());
    if (push) begin
      if (fq.size() < DEPTH) fq.push_back(res);
      else movf = 1;
    end
    check_model();
  endtask

  task automatic do_reset(input bit v);
    rst_n = 0;
    i_valid = v;
    i_y = 8'd77;
    i_ready = 1;
    @(posedge clk); #1;
    grp.delete();
    fq.delete();
    movf = 0;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_ovf", 32'(o_ovf), 0);
    chk("rst_level", 32'(o_level), 0);
    rst_n = 1;
  endtask

  initial begin
    do_reset(0);
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 1);
    chk("tp1_valid", 32'(o_valid), 1);
    chk("tp1_data", 32'(o_data), RB != 0 ? 3 : 2);
    step(0, 0, 1);
    chk("tp1_level", 32'(o_level), 0);

    for (int i = 0; i < 8; i++) begin
      step(1, 8'd255, 1);
      if (i % 4 == 3) chk("tp2_data", 32'(o_data), 255);
    end
    chk("tp2_ovf", 32'(o_ovf), 0);

    step(1, 8'd4, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      chk("tp3_gap", 32'(o_valid), 0);
    end
    for (int i = 0; i < 3; i++) step(1, 8'd4, 1);
    chk("tp3_data", 32'(o_data), 4);
    step(0, 0, 1);
    chk("tp3_single", 32'(o_valid), 0);

    do_reset(0);
    for (int i = 0; i < 20; i++) step(1, 8'd8, 0);
    chk("tp4_level", 32'(o_level), 4);
    chk("tp4_ovf", 32'(o_ovf), 1);
    for (int i = 0; i < 4; i++) begin
      chk("tp4_data", 32'(o_data), 8);
      step(0, 0, 1);
    end
    chk("tp4_empty", 32'(o_valid), 0);
    chk("tp4_sticky", 32'(o_ovf), 1);

    do_reset(0);
    for (int g = 1; g <= 4; g++)
      for (int i = 0; i < 4; i++) step(1, 8'(10 * g), 0);
    chk("tp5_full", 32'(o_level), 4);
    for (int i = 0; i < 3; i++) step(1, 8'd50, 0);
    step(1, 8'd50, 1);
    chk("tp5_level", 32'(o_level), 4);
    chk("tp5_ovf", 32'(o_ovf), 0);
    for (int g = 2; g <= 5; g++) begin
      chk("tp5_order", 32'(o_data), 32'(10 * g));
      step(0, 0, 1);
    end

    do_reset(0);
    step(1, 8'd9, 1);
    step(1, 8'd9, 1);
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1, 8'd6, 1);
    chk("tp6_data", 32'(o_data), 6);
    chk("tp6_level", 32'(o_level), 1);
    step(0, 0, 1);
    chk("tp6_single", 32'(o_valid), 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(0, 1) == 1);
      else step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 99) < (i % 600 < 300 ? 15 : 80));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_decim_out.md
# fir_decim_out

Output decimation stage placed directly downstream of the FIR1 filter. It consumes the filter's 8-bit output sample on every valid cycle and block-averages groups of 2^LOG2_DECIM samples. Each average goes into a small output FIFO that drains over a valid/ready handshake. It reduces the sample rate by 2^LOG2_DECIM and decouples the free-running filter from a back-pressuring consumer.

## Interface
- LOG2_DECIM, default 2: log2 of decimation factor D (D = 4 at default); legal range 1..4.
- LOG2_DEPTH, default 2: log2 of output FIFO depth (4 entries at default); legal range 1..4.

- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  reset, synchronous and active-low.
- i_y  input  8  unsigned sample, connected to FIR1 o_y.
- i_valid  input  1  i_y carries a sample this cycle.
- o_data  output  8  decimated sample at FIFO head.
- o_valid  output  1  FIFO not empty; o_data is valid.
- i_ready  input  1  consumer accepts o_data this cycle.
- o_ovf  output  1  sticky flag: a result was dropped because the FIFO was full.
- o_level  output  LOG2_DEPTH+1  current FIFO occupancy, 0..2^LOG2_DEPTH.

## Operation
- Accumulator `acc` is 8+LOG2_DECIM bits, unsigned. It never overflows, because max sum = 255·D.
- Phase counter `cnt` is LOG2_DECIM bits and counts accepted samples 0..D-1.
- Cycles with i_valid=0 are ignored: acc and cnt hold.
- i_valid=1, cnt<D-1:
  - acc <= acc + i_y
  - cnt <= cnt + 1
- i_valid=1, cnt==D-1 (final sample of the group):
  - sum = acc + i_y
  - result = sum >> LOG2_DECIM, or rounded per Configuration
  - push result to the FIFO
  - acc <= 0, cnt <= 0
- FIFO:
  - circular buffer with read/write pointers of LOG2_DEPTH+1 bits, using the wrap bit for full/empty detection.
  - pop when o_valid && i_ready.
- Push while full:
  - if a pop occurs in the same cycle, the push succeeds and level is unchanged.
  - otherwise the result is dropped, o_ovf <= 1, and FIFO contents are unchanged.
- Pop while empty is a no-op; o_valid=0 prevents it.
- Simultaneous push and pop with level between 1 and DEPTH-1: level is unchanged and both pointers advance.
- o_ovf is cleared only by reset.

## Timing
- Reset (rst_n=0 at a clk edge) clears all state:
  - o_valid=0, o_data=0, o_ovf=0, o_level=0
  - acc=0, cnt=0, both FIFO pointers 0
- Reset asserted mid-group discards the partial accumulation; the next accepted sample is group sample 0.
- Latency: the result of a group appears on o_data with o_valid=1 one cycle after the edge that accepts the group's final sample, provided the FIFO was empty.
- o_data is taken from a registered head. It must not change while o_valid=1 and i_ready=0.
- o_level updates on the same edge as the push or pop that changes it.
- Throughput: one sample in per cycle, one result out per cycle. The FIFO never fills when i_ready is held at 1.

## Configuration
- Macro FIR_DECIM_ROUND_EN selects the rounding mode:
  - Defined: result = (sum + 2^(LOG2_DECIM-1)) >> LOG2_DECIM, i.e. round-half-up. No saturation logic is needed, because the max value 255·D + D/2 still shifts to 255.
  - Undefined: result = sum >> LOG2_DECIM (truncation). The rounding adder is not synthesized.

## Test plan
- Reset, then i_y=1,2,3,4 with i_valid=1, i_ready=1:
  - one cycle after the 4th sample, o_valid=1.
  - o_data=2 (truncate) or 3 (ROUND_EN).
  - o_level returns to 0 after the pop.
- i_y=255 for 8 consecutive valid cycles:
  - two results, each o_data=255 in both modes.
  - o_ovf stays 0.
- i_valid gaps: i_y=4, then 3 idle cycles, then 4,4,4:
  - exactly one result, o_data=4.
  - no result emitted during the gaps.
- i_ready=0, feed 5 groups of constant value 8:
  - o_level reaches 4.
  - 5th result dropped, o_ovf=1.
  - raise i_ready: four results of 8, then o_valid=0; o_ovf stays 1.
- FIFO full plus simultaneous push and pop:
  - fill to 4, then assert i_ready on the same edge as a new push.
  - o_level stays 4 and o_ovf stays 0.
  - o_data sequence is preserved in order.
- Assert rst_n=0 after 2 of 4 group samples, release, feed 6,6,6,6:
  - single result o_data=6.
  - all outputs read 0 during reset.
